car_lane_controller: RTL

- Upstream stage of player_control. Generates the horizontal positions car_x1..car_x8 of the eight traffic cars.
- Consumes the speed_car level value that player_control produces, so cars move faster as the level rises.
- Outputs feed both player_control (collision detection) and the VGA renderer.
- Single clock domain, pixel coordinates, one movement step per internal tick.

---
 rtl/car_lane_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/car_lane_controller.sv
// car_lane_controller: moves eight traffic-car x positions one step per speed-scaled tick.
// Optional wrap jitter from a 16-bit LFSR when CAR_LFSR_JITTER_EN is defined.
module car_lane_controller #(
  parameter int H_DISPLAY    = 640,
  parameter int BASE_PERIOD  = 400000,
  parameter int PERIOD_STEP  = 15000,
  parameter int MIN_PERIOD   = 50000,
  parameter int INIT_SPACING = 80
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_run,
  input  logic       i_restart,
  input  logic [4:0] speed_car,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [9:0] car_x5,
  output logic [9:0] car_x6,
  output logic [9:0] car_x7,
  output logic [9:0] car_x8,
  output logic       o_tick
);
  localparam logic [31:0] BP = 32'(BASE_PERIOD);
  localparam logic [31:0] PS = 32'(PERIOD_STEP);
  localparam logic [31:0] MP = 32'(MIN_PERIOD);
  localparam logic [10:0] HD = 11'(H_DISPLAY);
  logic [31:0] cnt_q, cnt_d, prod, period;
  logic        tick_q, tick_d, hit;
  logic [9:0]  x_q [8];
  logic [9:0]  x_d [8];
  logic [10:0] jit;
  function automatic logic [9:0] init_x(input int n);
    return 10'(n * INIT_SPACING);
  endfunction
  function automatic logic [9:0] move(input logic [9:0] x, input logic right,
                                     input logic [10:0] s, input logic [10:0] j);
    logic [10:0] xe;
    xe = {1'b0, x};
    if (right) return (xe + s >= HD) ? 10'(xe + s - HD + j) : 10'(xe + s);
    return (xe < s) ? 10'(xe + HD - s - j) : 10'(xe - s);
  endfunction
`ifdef CAR_LFSR_JITTER_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr_q <= 16'hACE1;
    else if (i_restart) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign jit = {5'd0, lfsr_q[5:0]};
`else
  assign jit = '0;
`endif
  // Clamp instead of subtracting so high levels cannot underflow the period.
  assign prod   = 32'(speed_car) * PS;
  assign period = (prod > BP - MP) ? MP : BP - prod;
  assign hit    = i_run && (cnt_q >= period - 32'd1);
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    for (int n = 0; n < 8; n++) x_d[n] = x_q[n];
    if (i_restart) begin
      cnt_d = '0;
      for (int n = 0; n < 8; n++) x_d[n] = init_x(n);
    end else if (hit) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      for (int n = 0; n < 8; n++) x_d[n] = move(x_q[n], n % 2 == 0, n < 4 ? 11'd1 : 11'd2, jit);
    end else if (i_run) begin
      cnt_d = cnt_q + 32'd1;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      for (int n = 0; n < 8; n++) x_q[n] <= init_x(n);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      for (int n = 0; n < 8; n++) x_q[n] <= x_d[n];
    end
  end
  assign car_x1 = x_q[0];
  assign car_x2 = x_q[1];
  assign car_x3 = x_q[2];
  assign car_x4 = x_q[3];
  assign car_x5 = x_q[4];
  assign car_x6 = x_q[5];
  assign car_x7 = x_q[6];
  assign car_x8 = x_q[7];
  assign o_tick = tick_q;
endmodule
